// File: rtl/neuron_core_pkg.sv
// Shared definitions for the neuron core address decoder: region encodings,
// FSM state type and default core geometry.
package neuron_core_pkg;

  localparam int DEFAULT_NUM_NEURONS = 256;
  localparam int DEFAULT_NUM_PARAMS  = 32;

  localparam logic [1:0] REGION_SYNAP = 2'b00;
  localparam logic [1:0] REGION_PARAM = 2'b01;
  localparam logic [1:0] REGION_SPIKE = 2'b10;
  localparam logic [1:0] REGION_NONE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Index width for a field addressing n entries; never narrower than 1 bit.
  function automatic int field_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_core_region_dec.sv
// Combinational region and field extractor applied to the latched bus address.
// Splits the address into region select, parameter index and word index, and
// flags unmapped / out-of-range parameter accesses.
module neuron_core_region_dec
  import neuron_core_pkg::*;
#(
  parameter int  NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int  NUM_PARAMS  = DEFAULT_NUM_PARAMS,
  parameter int  REGION_LSB  = 13,
  parameter int  PARAM_LSB   = 4,
  localparam int WW          = field_w(NUM_NEURONS),
  localparam int PW          = field_w(NUM_PARAMS)
) (
  input  logic [31:0]   adr,
  output logic          sel_synap,
  output logic          sel_param,
  output logic          sel_spike,
  output logic          unmapped,
  output logic          param_range_err,
  output logic [PW-1:0] param_num,
  output logic [WW-1:0] word_idx
);

  logic [1:0]    region;
  logic [PW-1:0] param_field;

  // Address bits outside the decoded fields are intentionally ignored.
  logic unused_adr;
  assign unused_adr = ^adr;

  // Slice the fields and decode the region into one-hot selects.
  always_comb begin
    region          = adr[REGION_LSB +: 2];
    param_field     = adr[PARAM_LSB +: PW];
    word_idx        = adr[2 +: WW];
    sel_synap       = (region == REGION_SYNAP);
    sel_param       = (region == REGION_PARAM);
    sel_spike       = (region == REGION_SPIKE);
    unmapped        = (region == REGION_NONE);
    param_num       = sel_param ? param_field : '0;
    param_range_err = sel_param && (int'(param_field) >= NUM_PARAMS);
  end

endmodule

// File: rtl/neuron_core_addr_decoder.sv
// Registered Wishbone address decoder and access sequencer for the neuron core.
// Captures one access, holds the decoded selects stable for WAIT_CYCLES wait
// states, then acknowledges for one cycle. Dropping cyc mid-access aborts it.
// Optional feature: define NEURON_DECODE_ERR_EN to add wbs_err_o, which
// replaces ack for unmapped or out-of-range parameter accesses.
module neuron_core_addr_decoder
  import neuron_core_pkg::*;
#(
  parameter int  NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int  NUM_PARAMS  = DEFAULT_NUM_PARAMS,
  parameter int  REGION_LSB  = 13,
  parameter int  PARAM_LSB   = 4,
  parameter int  WAIT_CYCLES = 1,
  localparam int WW          = field_w(NUM_NEURONS),
  localparam int PW          = field_w(NUM_PARAMS)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [31:0]   wbs_adr_i,
  output logic          wbs_ack_o,
  output logic          sel_synap_o,
  output logic          sel_param_o,
  output logic          sel_spike_o,
  output logic [PW-1:0] param_num_o,
  output logic [WW-1:0] word_idx_o,
  output logic          we_o,
  output logic          busy_o
`ifdef NEURON_DECODE_ERR_EN
  ,
  output logic          wbs_err_o
`endif
);

  // Counter preload so that WAIT lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic        capture;
  logic        busy;
  logic        respond;

  logic [31:0] adr_held;
  logic        we_held;

  logic          dec_synap;
  logic          dec_param;
  logic          dec_spike;
  logic          dec_unmapped;
  logic          dec_range_err;
  logic [PW-1:0] dec_param_num;
  logic [WW-1:0] dec_word_idx;

  neuron_core_region_dec #(
    .NUM_NEURONS (NUM_NEURONS),
    .NUM_PARAMS  (NUM_PARAMS),
    .REGION_LSB  (REGION_LSB),
    .PARAM_LSB   (PARAM_LSB)
  ) region_dec (
    .adr             (adr_held),
    .sel_synap       (dec_synap),
    .sel_param       (dec_param),
    .sel_spike       (dec_spike),
    .unmapped        (dec_unmapped),
    .param_range_err (dec_range_err),
    .param_num       (dec_param_num),
    .word_idx        (dec_word_idx)
  );

  // Next-state logic: capture in IDLE, count down in WAIT, single-cycle ACK.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          capture    = 1'b1;
          cnt_next   = WAIT_LOAD;
          state_next = (WAIT_CYCLES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_next = ACK;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ACK: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Address and write-enable are latched only at capture; outputs are gated by busy.
  always_ff @(posedge wb_clk_i) begin
    if (capture) begin
      adr_held <= wbs_adr_i;
      we_held  <= wbs_we_i;
    end
  end

  // Decoded outputs are live only while an access is in flight.
  always_comb begin
    busy        = (state != IDLE);
    respond     = (state == ACK) && wbs_cyc_i;
    busy_o      = busy;
    sel_synap_o = busy && dec_synap;
    sel_param_o = busy && dec_param;
    sel_spike_o = busy && dec_spike;
    param_num_o = busy ? dec_param_num : '0;
    word_idx_o  = busy ? dec_word_idx : '0;
    we_o        = busy && we_held;
  end

`ifdef NEURON_DECODE_ERR_EN
  // Unmapped or out-of-range parameter accesses terminate with err instead of ack.
  always_comb begin
    wbs_ack_o = respond && !(dec_unmapped || dec_range_err);
    wbs_err_o = respond && (dec_unmapped || dec_range_err);
  end
`else
  logic unused_err;
  assign unused_err = dec_unmapped ^ dec_range_err;

  // Every access terminates with ack, including unmapped ones.
  always_comb begin
    wbs_ack_o = respond;
  end
`endif

endmodule

// File: tb/tb_neuron_core_addr_decoder.sv
// Directed, table-driven bench for neuron_core_addr_decoder. Three instances
// with WAIT_CYCLES of 0, 1 and 3 share the bus inputs; each vector selects
// the instance whose outputs are compared. Honours NEURON_DECODE_ERR_EN.
module tb_neuron_core_addr_decoder;

`ifdef NEURON_DECODE_ERR_EN
  localparam logic ERR_MODE = 1'b1;
`else
  localparam logic ERR_MODE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;

  logic       ack   [3];
  logic       err   [3];
  logic       synap [3];
  logic       param [3];
  logic       spike [3];
  logic [4:0] pnum  [3];
  logic [7:0] widx  [3];
  logic       weo   [3];
  logic       busy  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    neuron_core_addr_decoder #(
      .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 1 : 3)
    ) dut (
      .wb_clk_i    (clk),
      .wb_rst_n    (rst_n),
      .wbs_cyc_i   (cyc),
      .wbs_stb_i   (stb),
      .wbs_we_i    (we),
      .wbs_adr_i   (adr),
      .wbs_ack_o   (ack[g]),
      .sel_synap_o (synap[g]),
      .sel_param_o (param[g]),
      .sel_spike_o (spike[g]),
      .param_num_o (pnum[g]),
      .word_idx_o  (widx[g]),
      .we_o        (weo[g]),
      .busy_o      (busy[g])
`ifdef NEURON_DECODE_ERR_EN
      ,
      .wbs_err_o   (err[g])
`endif
    );
`ifndef NEURON_DECODE_ERR_EN
    assign err[g] = 1'b0;
`endif
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          k;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   passed;

  function automatic logic [19:0] mk(input logic a, input logic e, input logic sy,
                                     input logic pa, input logic sp, input logic [4:0] pn,
                                     input logic [7:0] wi, input logic wo, input logic bz);
    return {a, e, sy, pa, sp, pn, wi, wo, bz};
  endfunction

  function automatic logic [19:0] act_vec(input int k);
    return {ack[k], err[k], synap[k], param[k], spike[k], pnum[k], widx[k], weo[k], busy[k]};
  endfunction

  task automatic add(input string name, input int k, input logic c, input logic s,
                     input logic w, input logic [31:0] a, input logic [19:0] e);
    vec_t v;
    v.name = name;
    v.k    = k;
    v.cyc  = c;
    v.stb  = s;
    v.we   = w;
    v.adr  = a;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  localparam logic [19:0] ZERO = 20'h0;

  initial begin
    total  = 0;
    passed = 0;

    // Instance index: 0 -> WAIT_CYCLES=0, 1 -> 1, 2 -> 3
    add("idle",     2, 0, 0, 0, 32'h0,      ZERO);
    // Parameter read, one wait state; address changes while busy are ignored
    add("prm_cap",  1, 1, 1, 0, 32'h2050,   mk(0, 0, 0, 1, 0, 5, 20, 0, 1));
    add("prm_ack",  1, 1, 0, 1, 32'h6FFC,   mk(1, 0, 0, 1, 0, 5, 20, 0, 1));
    add("prm_clr",  1, 0, 0, 0, 32'h0,      ZERO);
    // Synapse write, zero wait states
    add("syn_ack",  0, 1, 1, 1, 32'h03FC,   mk(1, 0, 1, 0, 0, 0, 255, 1, 1));
    add("syn_clr",  0, 0, 0, 0, 32'h0,      ZERO);
    // Spike access, three wait states, full latency
    add("spk_cap",  2, 1, 1, 0, 32'h4008,   mk(0, 0, 0, 0, 1, 0, 2, 0, 1));
    add("spk_w1",   2, 1, 0, 0, 32'h4008,   mk(0, 0, 0, 0, 1, 0, 2, 0, 1));
    add("spk_w2",   2, 1, 0, 0, 32'h4008,   mk(0, 0, 0, 0, 1, 0, 2, 0, 1));
    add("spk_ack",  2, 1, 0, 0, 32'h4008,   mk(1, 0, 0, 0, 1, 0, 2, 0, 1));
    add("spk_clr",  2, 0, 0, 0, 32'h0,      ZERO);
    // Abort: cyc dropped during the second wait cycle
    add("ab_cap",   2, 1, 1, 0, 32'h4008,   mk(0, 0, 0, 0, 1, 0, 2, 0, 1));
    add("ab_w1",    2, 1, 0, 0, 32'h4008,   mk(0, 0, 0, 0, 1, 0, 2, 0, 1));
    add("ab_drop",  2, 0, 0, 0, 32'h4008,   ZERO);
    add("ab_idle1", 2, 1, 0, 0, 32'h4008,   ZERO);
    add("ab_idle2", 2, 1, 0, 0, 32'h4008,   ZERO);
    add("ab_idle3", 2, 0, 0, 0, 32'h0,      ZERO);
    // Unmapped region still sequenced, no selects
    add("unm_cap",  1, 1, 1, 0, 32'h6000,   mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    add("unm_resp", 1, 1, 0, 0, 32'h6000,   mk(!ERR_MODE, ERR_MODE, 0, 0, 0, 0, 0, 0, 1));
    add("unm_clr",  1, 0, 0, 0, 32'h0,      ZERO);
    // Back-to-back parameter accesses with stb held high
    add("b2b_c1",   1, 1, 1, 0, 32'h2030,   mk(0, 0, 0, 1, 0, 3, 12, 0, 1));
    add("b2b_a1",   1, 1, 1, 0, 32'h2030,   mk(1, 0, 0, 1, 0, 3, 12, 0, 1));
    add("b2b_i",    1, 1, 1, 0, 32'h2070,   ZERO);
    add("b2b_c2",   1, 1, 1, 0, 32'h2070,   mk(0, 0, 0, 1, 0, 7, 28, 0, 1));
    add("b2b_a2",   1, 1, 1, 0, 32'h2070,   mk(1, 0, 0, 1, 0, 7, 28, 0, 1));
    add("b2b_clr",  1, 0, 0, 0, 32'h0,      ZERO);

    // Reset held with a request on the bus: everything stays zero
    rst_n = 1'b0;
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = 1'b0;
    adr   = 32'h2050;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("rst_out%0d", k), act_vec(k), ZERO);

    // Release away from the edge; the next edge captures
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_cap_w1", act_vec(1), mk(0, 0, 0, 1, 0, 5, 20, 0, 1));
    check("first_cap_w0", act_vec(0), mk(1, 0, 0, 1, 0, 5, 20, 0, 1));

    foreach (vecs[i]) begin
      cyc = vecs[i].cyc;
      stb = vecs[i].stb;
      we  = vecs[i].we;
      adr = vecs[i].adr;
      @(posedge clk);
      #1;
      check(vecs[i].name, act_vec(vecs[i].k), vecs[i].exp);
    end

    // Reset asserted mid-access: outputs clear at once, no ack follows
    cyc = 1'b1;
    stb = 1'b1;
    we  = 1'b1;
    adr = 32'h4008;
    @(posedge clk);
    #1;
    check("mrst_cap", act_vec(2), mk(0, 0, 0, 0, 1, 0, 2, 1, 1));
    stb = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_async", act_vec(2), ZERO);
    @(posedge clk);
    #1;
    check("mrst_hold", act_vec(2), ZERO);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("mrst_noack%0d", c), act_vec(2), ZERO);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/neuron_core_addr_decoder.md
Name: neuron_core_addr_decoder

Overview:
- Registered, parametrised Wishbone address decoder and access sequencer for the neuron core.
- Captures one slave access, decodes it into a region select (synapse matrix / neuron parameter / spike output) plus a word index and a parameter index, then holds those selects stable for a programmable number of wait states before returning ack.
- Sits between the Caravel Wishbone slave port and the core's synapse SRAM, parameter register file and spike-out buffer.
- Generalises the earlier combinational decoder in neuron count, parameter count, region position and access latency.

Parameters:
- NUM_NEURONS, 256, neurons per core; sets word_idx_o width WW = clog2(NUM_NEURONS).
- NUM_PARAMS, 32, parameter words per neuron; PW = clog2(NUM_PARAMS).
- REGION_LSB, 13, LSB of the 2-bit region field adr[REGION_LSB+1:REGION_LSB].
- PARAM_LSB, 4, LSB of the parameter index field adr[PARAM_LSB+PW-1:PARAM_LSB].
- WAIT_CYCLES, 1, wait states between capture and ack; legal range 0..15.

Ports:
- wb_clk_i  in  1  core clock
- wb_rst_n  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  bus cycle valid
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  one-cycle access acknowledge
- sel_synap_o  out  1  synapse-matrix region selected
- sel_param_o  out  1  parameter region selected
- sel_spike_o  out  1  spike-out region selected
- param_num_o  out  PW  parameter index; zero unless sel_param_o
- word_idx_o  out  WW  word index adr[WW+1:2]
- we_o  out  1  latched write enable
- busy_o  out  1  access in progress (state != IDLE)

Behaviour:
- Reset (asynchronous, active-low): state IDLE, wait counter 0, and every output 0.
- Region decode of the latched address:
  - 00 → synapse
  - 01 → parameter (param_num_o = field)
  - 10 → spike
  - 11 → unmapped (no select asserted)
- FSM states: IDLE, WAIT, ACK.
- IDLE: when cyc & stb are sampled high, latch adr and we, and register the selects, word_idx_o, param_num_o and we_o.
  - If WAIT_CYCLES = 0, go to ACK.
  - Otherwise load counter = WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter each cycle; when counter = 0, go to ACK.
- ACK: wbs_ack_o = 1 for exactly this cycle, then go to IDLE; selects clear on the same edge.
- Latency: ack is high in the cycle WAIT_CYCLES+1 edges after the capture edge.
- Selects, indices and we_o stay stable from the cycle after capture through the ACK cycle inclusive; they never change mid-access.
- Address changes while busy are ignored.
- Abort: cyc low sampled in WAIT or ACK returns the FSM to IDLE, clears all outputs and suppresses ack.
- Back-to-back accesses: IDLE after ACK may capture a new request on the very next edge. Minimum spacing is WAIT_CYCLES+2 cycles per access.
- Unmapped region (11): access is still sequenced and acked with all selects 0, so the bus never hangs.
- Address bits outside the decoded fields are don't-care.
- Reset asserted mid-access: immediate return to the reset state; no ack is produced.

Optional Feature:
- Macro: NEURON_DECODE_ERR_EN.
- With the macro: an extra output port wbs_err_o (1 bit, reset 0).
  - An unmapped-region access asserts wbs_err_o instead of wbs_ack_o in the ACK-state cycle.
  - The parameter region also errors when the parameter field ≥ NUM_PARAMS (non-power-of-2 NUM_PARAMS).
- Without the macro: no wbs_err_o port; every access acks.

Decomposition:
- Shared package neuron_core_pkg holds:
  - region encodings REGION_SYNAP=2'b00, REGION_PARAM=2'b01, REGION_SPIKE=2'b10, REGION_NONE=2'b11;
  - the FSM state typedef;
  - default NUM_NEURONS/NUM_PARAMS constants.
- One natural sub-module: neuron_core_region_dec, a purely combinational region and field extractor instantiated on the latched address. The FSM and wait counter stay in the top module.

Test Plan:
- Reset: hold wb_rst_n low with stb high → all outputs 0. Release → first capture happens on the next edge.
- Parameter read with WAIT_CYCLES=1, adr=0x0000_2050:
  - sel_param_o=1 and param_num_o=5 from cycle 1;
  - ack only in cycle 2;
  - selects 0 in cycle 3.
- Synapse write with WAIT_CYCLES=0, adr=0x0000_03FC, we=1: sel_synap_o=1, word_idx_o=255, we_o=1, ack in cycle 1.
- Abort: spike access adr=0x0000_4008 with WAIT_CYCLES=3, cyc dropped in the second WAIT cycle → no ack, outputs 0, busy_o=0 next cycle.
- Unmapped adr=0x0000_6000:
  - without the macro: ack, no selects;
  - with NEURON_DECODE_ERR_EN: wbs_err_o pulses, ack stays 0.
- Back-to-back: two parameter accesses (param_num 3, then 7) with stb held high → second capture on the edge after the first ack, correct indices each time, exactly two ack pulses.
